melody_matcher: RTL and testbench

Consumes the thresholded one-hot note stream produced by the note-recognition stage and checks it against a stored melody, one note onset at a time. Tracks how far into the melody the player has got, flags wrong notes, and raises a sticky `matched` flag when the full melody has been played in order. Sits directly downstream of the note detector; its outputs drive LEDs and the graphics and score logic.

---
 rtl/melody_matcher.sv | 162 ++++++++++++++++
 tb/tb_melody_matcher.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/melody_matcher.sv
// melody_matcher: follows a one-hot note stream against a stored melody,
// one onset at a time, reporting progress, wrong notes and completion.
// Optional idle-timeout abort while tracking: define MELODY_MATCHER_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// st_idle  | nothing matched yet, waiting for melody[0]
// st_track | part of the melody matched, progress = notes matched so far
// st_done  | whole melody matched, matched held high until restart/rst

module melody_matcher #(
  parameter int w_note = 12,
  parameter int melody_len = 8,
  parameter logic [w_note*melody_len-1:0] melody = {
    12'h040, 12'h080, 12'h200, 12'h800, 12'h200, 12'h080, 12'h200, 12'h800},
  parameter int timeout_cycles = 100_000_000,
  parameter int w_prog = $clog2(melody_len + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [w_note-1:0] note_in,
  input  logic              restart,
  output logic [w_prog-1:0] progress,
  output logic [w_note-1:0] expected_note,
  output logic              matched,
  output logic              mismatch,
  output logic              timeout
);

  typedef enum logic [1:0] {st_idle, st_track, st_done} state_t;

  localparam logic [w_prog-1:0] len_p = w_prog'(melody_len);

  // Reject configurations the 27-bit idle counter or progress width cannot hold.
  if (timeout_cycles < 1 || timeout_cycles > (1 << 27) ||
      melody_len < 1 || melody_len > 15) begin : g_bad_cfg
    $error("melody_matcher: melody_len or timeout_cycles out of range");
  end

  // Melody lookup as a mux; indices past the end (DONE) read as no note.
  function automatic logic [w_note-1:0] note_at(input logic [w_prog-1:0] idx);
    note_at = '0;
    for (int i = 0; i < melody_len; i++) begin
      if (idx == w_prog'(i)) note_at = melody[i*w_note +: w_note];
    end
  endfunction

  state_t            state, state_nxt;
  logic [w_note-1:0] prev_note, note_clean;
  logic              note_valid, onset;
  logic [w_note-1:0] first_note, cur_note;
  logic [w_prog-1:0] prog_nxt, prog_inc;
  logic [w_note-1:0] exp_nxt;
  logic              matched_nxt, mismatch_nxt, timeout_nxt;
  logic              tmo_hit;

  assign note_valid = $onehot(note_in);
  assign note_clean = note_valid ? note_in : '0;
  assign onset      = note_valid && (note_in != prev_note);
  assign first_note = note_at('0);
  assign cur_note   = note_at(progress);
  assign prog_inc   = progress + w_prog'(1);

`ifdef MELODY_MATCHER_TIMEOUT_EN
  localparam logic [26:0] tmo_last = 27'(timeout_cycles - 1);

  logic [26:0] tmo_cnt, tmo_cnt_nxt;

  assign tmo_hit = (tmo_cnt == tmo_last);

  // Idle counter only runs while staying in TRACK without an onset.
  always_comb begin
    tmo_cnt_nxt = '0;
    if (state == st_track && state_nxt == st_track && !onset)
      tmo_cnt_nxt = tmo_cnt + 27'd1;
  end

  // Idle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt <= '0;
    else     tmo_cnt <= tmo_cnt_nxt;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and next-output decode; restart overrides any onset.
  always_comb begin
    state_nxt    = state;
    prog_nxt     = progress;
    mismatch_nxt = 1'b0;
    timeout_nxt  = 1'b0;
    if (restart) begin
      state_nxt = st_idle;
      prog_nxt  = '0;
    end else begin
      case (state)
        st_idle: begin
          if (onset) begin
            if (note_in == first_note) begin
              prog_nxt  = w_prog'(1);
              state_nxt = (melody_len == 1) ? st_done : st_track;
            end else begin
              mismatch_nxt = 1'b1;
            end
          end
        end
        st_track: begin
          if (onset) begin
            if (note_in == cur_note) begin
              prog_nxt = prog_inc;
              if (prog_inc == len_p) state_nxt = st_done;
            end else begin
              mismatch_nxt = 1'b1;
              if (note_in == first_note) begin
                prog_nxt = w_prog'(1);
              end else begin
                prog_nxt  = '0;
                state_nxt = st_idle;
              end
            end
          end else if (tmo_hit) begin
            prog_nxt    = '0;
            state_nxt   = st_idle;
            timeout_nxt = 1'b1;
          end
        end
        st_done: begin
          prog_nxt = len_p;
        end
        default: begin
          state_nxt = st_idle;
          prog_nxt  = '0;
        end
      endcase
    end
    matched_nxt = (state_nxt == st_done);
    exp_nxt     = (state_nxt == st_done) ? '0 : note_at(prog_nxt);
  end

  // State, registered outputs and the cleaned previous note.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= st_idle;
      progress      <= '0;
      expected_note <= note_at('0);
      matched       <= 1'b0;
      mismatch      <= 1'b0;
      timeout       <= 1'b0;
      prev_note     <= '0;
    end else begin
      state         <= state_nxt;
      progress      <= prog_nxt;
      expected_note <= exp_nxt;
      matched       <= matched_nxt;
      mismatch      <= mismatch_nxt;
      timeout       <= timeout_nxt;
      prev_note     <= note_clean;
    end
  end

endmodule

// File: tb/tb_melody_matcher.sv
// Bench for melody_matcher: directed vector table, hand-written timeout and
// async-reset sequences, and random stimulus against a behavioural model.

module tb_melody_matcher;

  localparam logic [11:0] N_C = 12'h800;
  localparam logic [11:0] N_D = 12'h200;
  localparam logic [11:0] N_E = 12'h080;
  localparam logic [11:0] N_F = 12'h040;
  localparam logic [11:0] N_G = 12'h010;
  localparam logic [11:0] N_Z = 12'h000;
  localparam logic [11:0] N_MH = 12'h801;
  localparam int TMO = 100;
  localparam logic [95:0] MEL = {N_F, N_E, N_D, N_C, N_D, N_E, N_D, N_C};
`ifdef MELODY_MATCHER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] note_in;
  logic        restart;
  logic [3:0]  progress;
  logic [11:0] expected_note;
  logic        matched, mismatch, timeout;

  melody_matcher #(
    .w_note(12), .melody_len(8), .melody(MEL), .timeout_cycles(TMO)
  ) dut (
    .clk(clk), .rst(rst), .note_in(note_in), .restart(restart),
    .progress(progress), .expected_note(expected_note), .matched(matched),
    .mismatch(mismatch), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: melody as a plain array, element 0 played first.
  logic [11:0] mel [8] = '{N_C, N_D, N_E, N_D, N_C, N_D, N_E, N_F};
  int          m_prog;
  bit          m_done, m_mm, m_to;
  logic [11:0] m_prev;
  int          m_idle;

  typedef struct {
    logic [11:0] note;
    logic        rs;
    int          prog;
    logic        mt;
    logic        mm;
    logic [11:0] expn;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [11:0] n, input logic rs, input int p,
                     input logic mt, input logic mm, input logic [11:0] en);
    vec_t v;
    v.note = n; v.rs = rs; v.prog = p; v.mt = mt; v.mm = mm; v.expn = en;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_prog = 0; m_done = 0; m_mm = 0; m_to = 0; m_prev = '0; m_idle = 0;
  endtask

  task automatic model_step(input logic [11:0] n, input logic rs);
    bit valid, on;
    valid = ($countones(n) == 1);
    on = valid && (n != m_prev);
    m_prev = valid ? n : '0;
    m_mm = 0;
    m_to = 0;
    if (rs) begin
      m_prog = 0; m_done = 0; m_idle = 0;
    end else if (m_done) begin
      m_idle = 0;
    end else if (on) begin
      m_idle = 0;
      if (n == mel[m_prog]) begin
        m_prog++;
        if (m_prog == 8) m_done = 1;
      end else begin
        m_mm = 1;
        m_prog = (n == mel[0]) ? 1 : 0;
      end
    end else if (TMO_EN && m_prog > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_prog = 0; m_to = 1; m_idle = 0;
      end
    end
  endtask

  task automatic check(input string name, input int p, input logic mt,
                       input logic mm, input logic to, input logic [11:0] en);
    vectors++;
    if (progress !== 4'(p) || matched !== mt || mismatch !== mm ||
        timeout !== to || expected_note !== en) begin
      miscompares++;
      $display("FAIL %s @%0t: got prog=%0d matched=%b mismatch=%b timeout=%b exp=%h, want prog=%0d matched=%b mismatch=%b timeout=%b exp=%h",
               name, $time, progress, matched, mismatch, timeout, expected_note,
               p, mt, mm, to, en);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, advance the model, compare DUT with the model.
  task automatic apply(input logic [11:0] n, input logic rs, input string name);
    note_in = n;
    restart = rs;
    tick();
    model_step(n, rs);
    check(name, m_prog, m_done, m_mm, m_to, m_done ? 12'h000 : mel[m_prog]);
  endtask

  logic [11:0] rnd_note, last_note;
  int k;

  initial begin
    rst = 1'b1;
    note_in = '0;
    restart = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", 0, 0, 0, 0, N_C);
    rst = 1'b0;

    // Full melody with gaps, DONE behaviour, restart beating an onset.
    add(N_C,0,1,0,0,N_D); add(N_Z,0,1,0,0,N_D); add(N_Z,0,1,0,0,N_D);
    add(N_D,0,2,0,0,N_E); add(N_Z,0,2,0,0,N_E); add(N_Z,0,2,0,0,N_E);
    add(N_E,0,3,0,0,N_D); add(N_Z,0,3,0,0,N_D); add(N_Z,0,3,0,0,N_D);
    add(N_D,0,4,0,0,N_C); add(N_Z,0,4,0,0,N_C); add(N_Z,0,4,0,0,N_C);
    add(N_C,0,5,0,0,N_D); add(N_Z,0,5,0,0,N_D); add(N_Z,0,5,0,0,N_D);
    add(N_D,0,6,0,0,N_E); add(N_Z,0,6,0,0,N_E); add(N_Z,0,6,0,0,N_E);
    add(N_E,0,7,0,0,N_F); add(N_Z,0,7,0,0,N_F); add(N_Z,0,7,0,0,N_F);
    add(N_F,0,8,1,0,N_Z); add(N_Z,0,8,1,0,N_Z); add(N_Z,0,8,1,0,N_Z);
    add(N_G,0,8,1,0,N_Z); add(N_Z,0,8,1,0,N_Z);
    add(N_C,1,0,0,0,N_C); add(N_Z,0,0,0,0,N_C);
    // Wrong note back to IDLE, wrong note equal to melody[0] restarts at 1.
    add(N_C,0,1,0,0,N_D); add(N_Z,0,1,0,0,N_D);
    add(N_D,0,2,0,0,N_E); add(N_Z,0,2,0,0,N_E);
    add(N_G,0,0,0,1,N_C); add(N_Z,0,0,0,0,N_C);
    add(N_C,0,1,0,0,N_D); add(N_Z,0,1,0,0,N_D);
    add(N_D,0,2,0,0,N_E); add(N_Z,0,2,0,0,N_E);
    add(N_C,0,1,0,1,N_D); add(N_Z,0,1,0,0,N_D);
    // Held note counts once; multi-hot is no note.
    add(N_Z,1,0,0,0,N_C);
    add(N_C,0,1,0,0,N_D);
    for (int i = 0; i < 49; i++) add(N_C,0,1,0,0,N_D);
    add(N_Z,0,1,0,0,N_D); add(N_Z,0,1,0,0,N_D);
    add(N_C,0,1,0,1,N_D); add(N_Z,0,1,0,0,N_D);
    add(N_MH,0,1,0,0,N_D); add(N_MH,0,1,0,0,N_D); add(N_Z,0,1,0,0,N_D);
    // Back-to-back onsets, then a wrong onset after a multi-hot gap.
    add(N_Z,1,0,0,0,N_C);
    add(N_C,0,1,0,0,N_D); add(N_D,0,2,0,0,N_E); add(N_E,0,3,0,0,N_D);
    add(N_E,0,3,0,0,N_D); add(N_MH,0,3,0,0,N_D);
    add(N_E,0,0,0,1,N_C); add(N_MH,0,0,0,0,N_C); add(N_Z,0,0,0,0,N_C);

    foreach (tbl[i]) begin
      apply(tbl[i].note, tbl[i].rs, "table_model");
      check($sformatf("table[%0d]", i), tbl[i].prog, tbl[i].mt, tbl[i].mm,
            1'b0, tbl[i].expn);
    end

    // Idle timeout behaviour.
    apply(N_Z, 1, "tmo_restart");
    apply(N_C, 0, "tmo_first");
`ifdef MELODY_MATCHER_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) apply(N_Z, 0, "tmo_wait");
    apply(N_Z, 0, "tmo_fire_model");
    check("tmo_fire", 0, 0, 0, 1, N_C);
    apply(N_Z, 0, "tmo_after");
    check("tmo_pulse_one_cycle", 0, 0, 0, 0, N_C);
    apply(N_C, 0, "tmo2_first");
    for (int i = 0; i < TMO - 1; i++) apply(N_Z, 0, "tmo2_wait");
    apply(N_D, 0, "tmo2_onset_model");
    check("tmo_onset_wins", 2, 0, 0, 0, N_E);
`else
    for (int i = 0; i < 1000; i++) apply(N_Z, 0, "notmo_wait");
    check("no_timeout", 1, 0, 0, 0, N_D);
`endif

    // Asynchronous reset at progress 5.
    apply(N_Z, 1, "ar_restart");
    apply(N_C, 0, "ar_n1"); apply(N_Z, 0, "ar_g1");
    apply(N_D, 0, "ar_n2"); apply(N_Z, 0, "ar_g2");
    apply(N_E, 0, "ar_n3"); apply(N_Z, 0, "ar_g3");
    apply(N_D, 0, "ar_n4"); apply(N_Z, 0, "ar_g4");
    apply(N_C, 0, "ar_n5");
    check("ar_at5", 5, 0, 0, 0, N_D);
    note_in = N_D;
    #3 rst = 1'b1;
    #1 check("ar_async_values", 0, 0, 0, 0, N_C);
    #1 rst = 1'b0;
    model_reset();
    apply(N_D, 0, "ar_first_model");
    check("ar_first_vs_mel0", 0, 0, 1, 0, N_C);
    apply(N_Z, 0, "ar_gap");
    apply(N_C, 0, "ar_c");
    check("ar_c_tracks", 1, 0, 0, 0, N_D);

    // Random stream biased towards the expected note.
    last_note = N_C;
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3: rnd_note = N_Z;
        4, 5, 6:    rnd_note = m_done ? 12'(1 << $urandom_range(0, 11)) : mel[m_prog];
        7:          rnd_note = last_note;
        8:          rnd_note = 12'(1 << $urandom_range(0, 11));
        default: begin
          rnd_note = 12'($urandom);
          if ($countones(rnd_note) < 2) rnd_note = rnd_note | 12'h003 | 12'h100;
        end
      endcase
      last_note = rnd_note;
      apply(rnd_note, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
